// File: rtl/median_pkg.sv
// +-----------------------------------------------------------------------+
// | median_pkg                                                            |
// | Shared FSM state encoding and counter width helpers for the median    |
// | window pipeline controller.                                           |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

package median_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_RUN   = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // A 3x3 window is complete once the pixel sits at row>=2 and col>=2.
    localparam int WIN_EDGE = 2;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/median_valid_sr.sv
// +-----------------------------------------------------------------------+
// | median_valid_sr                                                       |
// | Enable-gated shift register carrying valid (and optionally border)    |
// | tags alongside the median pipeline stages.                            |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module median_valid_sr #(
    parameter int DEPTH = 3,
    parameter int DW    = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    input  logic [DW-1:0] i_din,
    output logic [DW-1:0] o_tail,
    output logic          o_any
);

    logic [DEPTH-1:0][DW-1:0] r_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= '0;
        end else if (i_en) begin
            r_sr[0] <= i_din;
            for (int i = 1; i < DEPTH; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_tail = r_sr[DEPTH-1];
    // Border tags only ride with set valid tags, so any set bit means a pending result.
    assign o_any  = |r_sr;

endmodule

`default_nettype wire

// File: rtl/median_pipe_ctrl.sv
// +-----------------------------------------------------------------------+
// | median_pipe_ctrl                                                      |
// | Frame sequencer and valid tracking for a 3x3 median filter pipeline.  |
// | Optional macro MEDIAN_PIPE_CTRL_BORDER_EN adds a border-tagged output |
// | for every pixel instead of interior-only results.                     |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module median_pipe_ctrl
    import median_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int PIPE_DEPTH = 3
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              pix_valid,
    output logic                              pix_ready,
    output logic                              pipe_en,
    output logic [cnt_width(IMG_WIDTH)-1:0]   col,
    output logic [cnt_width(IMG_HEIGHT)-1:0]  row,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              busy,
    output logic                              done
`ifdef MEDIAN_PIPE_CTRL_BORDER_EN
    ,
    output logic                              border
`endif
);

    localparam int CW = cnt_width(IMG_WIDTH);
    localparam int RW = cnt_width(IMG_HEIGHT);
`ifdef MEDIAN_PIPE_CTRL_BORDER_EN
    localparam int DW = 2;
`else
    localparam int DW = 1;
`endif

    state_t          r_state;
    logic [CW-1:0]   r_col;
    logic [RW-1:0]   r_row;

    logic            w_active;
    logic            w_accept;
    logic            w_col_last;
    logic            w_row_last;
    logic            w_interior;
    logic [DW-1:0]   w_sr_in;
    logic [DW-1:0]   w_sr_tail;
    logic            w_sr_any;

    assign w_active   = (r_state == ST_FILL) || (r_state == ST_RUN);
    assign pix_ready  = w_active && (!out_valid || out_ready);
    assign w_accept   = pix_valid && pix_ready;
    assign w_col_last = (r_col == CW'(IMG_WIDTH - 1));
    assign w_row_last = (r_row == RW'(IMG_HEIGHT - 1));
    assign w_interior = (r_row >= RW'(WIN_EDGE)) && (r_col >= CW'(WIN_EDGE));

    always_comb begin
        pipe_en = 1'b0;
        case (r_state)
            ST_FILL, ST_RUN: pipe_en = w_accept;
            ST_FLUSH:        pipe_en = !out_valid || out_ready;
            default:         pipe_en = 1'b0;
        endcase
    end

`ifdef MEDIAN_PIPE_CTRL_BORDER_EN
    assign w_sr_in = {w_accept && !w_interior, w_accept};
    assign border  = w_sr_tail[1] && out_valid;
`else
    assign w_sr_in = w_accept && w_interior;
`endif

    median_valid_sr #(
        .DEPTH (PIPE_DEPTH),
        .DW    (DW)
    ) u_valid_sr (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (pipe_en),
        .i_din  (w_sr_in),
        .o_tail (w_sr_tail),
        .o_any  (w_sr_any)
    );

    assign out_valid = w_sr_tail[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_FILL;
                        r_col   <= '0;
                        r_row   <= '0;
                    end
                end
                ST_FILL, ST_RUN: begin
                    if (w_accept) begin
                        // The final pixel freezes the counters on the last position.
                        if ((r_state == ST_RUN) && w_row_last && w_col_last) begin
                            r_state <= ST_FLUSH;
                        end else if (w_col_last) begin
                            r_col <= '0;
                            r_row <= r_row + RW'(1);
                            if ((r_state == ST_FILL) && (r_row == RW'(1))) begin
                                r_state <= ST_RUN;
                            end
                        end else begin
                            r_col <= r_col + CW'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    if (!w_sr_any) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign col  = r_col;
    assign row  = r_row;
    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_DONE);

endmodule

`default_nettype wire
